// File: rtl/uart_rx_axi_reader.sv
// uart_rx_axi_reader: UART receiver -> byte FIFO -> AXI-Lite read-only slave (UART_RX_PARITY_EN adds even parity)
module uart_rx_axi_reader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic        rx,
  output logic        rx_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic rx_meta_q, rx_sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic push, frame_set, par_set, par_bad;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic frame_err_q, frame_err_d, overrun_q, overrun_d, parity_err_q, parity_err_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d, irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;
  logic empty, full, ar_hs, pop, push_ok, clr;
  logic [1:0] sel;
  logic [31:0] status;
  logic unused_addr;
  assign unused_addr = ^s_axi_araddr[1:0];
`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  assign par_bad = par_bad_q;
  // Parity mismatch latched at the parity bit centre, consumed at the stop bit
  always_ff @(posedge clk or negedge reset)
    if (!reset) par_bad_q <= 1'b0;
    else        par_bad_q <= par_bad_d;
`else
  assign par_bad = 1'b0;
`endif
  // Two-flop synchronizer; the line idles high
  always_ff @(posedge clk or negedge reset)
    if (!reset) {rx_meta_q, rx_sync_q} <= 2'b11;
    else        {rx_meta_q, rx_sync_q} <= {rx, rx_meta_q};
  // Receiver FSM: mid-bit sampling, LSB first
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    push = 1'b0;
    frame_set = 1'b0;
    par_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = rx_sync_q ? IDLE : START;
      end
      START: if (cnt_q == HALF_BIT) begin
        cnt_d = '0;
        bit_d = '0;
        state_d = rx_sync_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL_BIT) begin
        cnt_d = '0;
        shift_d = {rx_sync_q, shift_q[7:1]};
        bit_d = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (cnt_q == FULL_BIT) begin
        cnt_d = '0;
        par_bad_d = rx_sync_q != ^shift_q;
        state_d = STOP;
`else
        if (bit_q == 3'd7) state_d = STOP;
`endif
      end
      STOP: if (cnt_q == FULL_BIT) begin
        cnt_d = '0;
        push = rx_sync_q & ~par_bad;
        frame_set = ~rx_sync_q;
        par_set = par_bad;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // FIFO occupancy, sticky flags and the AXI read channel
  always_comb begin
    ar_hs = s_axi_arvalid & arready_q;
    sel = s_axi_araddr[3:2];
    empty = wr_ptr_q == rd_ptr_q;
    full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop = ar_hs && sel == 2'd0 && !empty;
    push_ok = push & (~full | pop);
    clr = ar_hs && sel == 2'd1;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    frame_err_d = frame_set | (frame_err_q & ~clr);
    overrun_d = (push & ~push_ok) | (overrun_q & ~clr);
    parity_err_d = par_set | (parity_err_q & ~clr);
    status = {27'h0, parity_err_q, overrun_q, frame_err_q, full, empty};
    rvalid_d = ar_hs | (rvalid_q & ~s_axi_rready);
    arready_d = ~rvalid_d;
    rdata_d = !ar_hs ? rdata_q :
              sel == 2'd0 ? (empty ? 32'h0 : {24'h0, mem_q[rd_ptr_q[AW-1:0]]}) :
              sel == 2'd1 ? status : 32'h0;
    rresp_d = !ar_hs ? rresp_q : (sel == 2'd1 || (sel == 2'd0 && !empty)) ? 2'b00 : 2'b10;
    irq_d = ~empty;
  end
  // FIFO storage needs no reset: only written entries are ever read
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  // State registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
      parity_err_q <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
      parity_err_q <= parity_err_d;
      arready_q <= arready_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      irq_q <= irq_d;
    end
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;
  assign rx_irq = irq_q;
endmodule

// File: tb/tb_uart_rx_axi_reader.sv
// tb_uart_rx_axi_reader: directed bench for uart_rx_axi_reader at CLKS_PER_BIT=16
module tb_uart_rx_axi_reader;
  localparam int CPB = 16;
  logic clk = 1'b0, reset = 1'b0, rx = 1'b1;
  logic [3:0] araddr = '0;
  logic arvalid = 1'b0, rready = 1'b0;
  logic arready, rvalid, rx_irq;
  logic [31:0] rdata;
  logic [1:0] rresp;
  int n_cmp = 0, n_err = 0;

  uart_rx_axi_reader #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .rx(rx), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v, input logic par_v);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(par_v);
`else
    rx = par_v;
`endif
    bit_out(stop_v);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    n = 0;
    araddr = a;
    arvalid = 1'b1;
    while (!arready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rvalid_timeout", {31'b0, rvalid}, 32'd1);
    d = rdata;
    r = rresp;
    rready = 1'b1;
    @(posedge clk);
    #1;
    rready = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] ed, input logic [1:0] er);
    logic [31:0] d;
    logic [1:0] r;
    axi_read(a, d, r);
    check({tag, "_data"}, d, ed);
    check({tag, "_resp"}, {30'b0, r}, {30'b0, er});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", {31'b0, arready}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", {30'b0, rresp}, 32'd0);
    check("rst_irq", {31'b0, rx_irq}, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(8'hA5, 1'b1, ^8'hA5);
    check("irq_set", {31'b0, rx_irq}, 32'd1);
    rd_chk("a5", 4'h0, 32'hA5, 2'b00);
    check("irq_clr", {31'b0, rx_irq}, 32'd0);
    rd_chk("st_after_a5", 4'h4, 32'h01, 2'b00);
    rd_chk("empty_data", 4'h0, 32'h0, 2'b10);
    rd_chk("st_after_empty", 4'h4, 32'h01, 2'b00);
    rd_chk("addr8", 4'h8, 32'h0, 2'b10);
    rd_chk("addrC", 4'hC, 32'h0, 2'b10);
    rd_chk("addr5_status", 4'h5, 32'h01, 2'b00);
    for (int i = 0; i < 17; i++) send(8'(i), 1'b1, ^8'(i));
    rd_chk("st_full_ovr", 4'h4, 32'h0A, 2'b00);
    for (int i = 0; i < 16; i++) rd_chk($sformatf("drain%0d", i), 4'h0, 32'(i), 2'b00);
    rd_chk("st_drained", 4'h4, 32'h01, 2'b00);
    send(8'h3C, 1'b0, ^8'h3C);
    rd_chk("st_frame", 4'h4, 32'h05, 2'b00);
    rd_chk("st_frame_clr", 4'h4, 32'h01, 2'b00);
    rx = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rd_chk("st_glitch", 4'h4, 32'h01, 2'b00);
    send(8'h5A, 1'b1, ^8'h5A);
    check("hold_arready_idle", {31'b0, arready}, 32'd1);
    araddr = 4'h0;
    arvalid = 1'b1;
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_rvalid%0d", i), {31'b0, rvalid}, 32'd1);
      check($sformatf("hold_rdata%0d", i), rdata, 32'h5A);
      check($sformatf("hold_arready%0d", i), {31'b0, arready}, 32'd0);
      @(posedge clk);
      #1;
    end
    rready = 1'b1;
    @(posedge clk);
    #1;
    rready = 1'b0;
    check("hold_rvalid_done", {31'b0, rvalid}, 32'd0);
    check("hold_arready_back", {31'b0, arready}, 32'd1);
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0);
    rd_chk("st_parity", 4'h4, 32'h11, 2'b00);
    send(8'h07, 1'b1, 1'b1);
    rd_chk("parity_ok", 4'h0, 32'h07, 2'b00);
`endif
    araddr = 4'h4;
    arvalid = 1'b1;
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    check("mid_rvalid", {31'b0, rvalid}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("mid_rst_arready", {31'b0, arready}, 32'd0);
    reset = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
